monitoreo_multicanal: RTL and testbench

Parametrised successor of the single-channel temperature monitor. It watches N_CANALES signed temperature sensors against run-time programmable low/high limits, with persistence filtering, hysteresis on exit and a sensor-timeout fault. It drives one heater/fan pair and a fault flag per channel, plus a global alert. It sits between the sensor sampling front-end and the actuator drivers.

---
 rtl/monitoreo_multicanal_if.sv | 33 +++
 rtl/monitoreo_multicanal.sv | 143 ++++++++++++++
 tb/tb_monitoreo_multicanal.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/monitoreo_multicanal_if.sv
// Sensor-side bundle of the multichannel monitor:
// samples and limits in, per-channel actuator/state outputs back.
interface monitoreo_multicanal_if #(
  parameter int N_CANALES  = 4,
  parameter int ANCHO_TEMP = 11
);
  logic [N_CANALES*ANCHO_TEMP-1:0] temp_entrada;
  logic [N_CANALES-1:0]            temp_valida;
  logic signed [ANCHO_TEMP-1:0]    lim_bajo;
  logic signed [ANCHO_TEMP-1:0]    lim_alto;
  logic [N_CANALES-1:0]            calefactor;
  logic [N_CANALES-1:0]            ventilador;
  logic [N_CANALES-1:0]            alerta_canal;
  logic [2*N_CANALES-1:0]          estado_actual;
  logic                            error_config;
  logic                            alerta;

  modport master (
    output temp_entrada, temp_valida,
    output lim_bajo, lim_alto,
    input  calefactor, ventilador,
    input  alerta_canal, estado_actual,
    input  error_config, alerta
  );

  modport slave (
    input  temp_entrada, temp_valida,
    input  lim_bajo, lim_alto,
    output calefactor, ventilador,
    output alerta_canal, estado_actual,
    output error_config, alerta
  );
endinterface

// File: rtl/monitoreo_multicanal.sv
// N-channel temperature monitor: persistence filter, exit
// hysteresis and sensor timeout per channel, global alert.
module monitoreo_multicanal #(
  parameter int N_CANALES    = 4,
  parameter int ANCHO_TEMP   = 11,
  parameter int PERSISTENCIA = 5,
  parameter int HISTERESIS   = 20,
  parameter int TIMEOUT      = 16
) (
  input logic clk,
  input logic arst_n,
  monitoreo_multicanal_if.slave bus
);

  localparam int AT  = ANCHO_TEMP;
  localparam int AT1 = ANCHO_TEMP + 1;
  localparam int WP  = $clog2(PERSISTENCIA + 1);
  localparam int WT  = $clog2(TIMEOUT + 1);

  localparam logic [WP-1:0] P_MAX = WP'(PERSISTENCIA);
  localparam logic [WT-1:0] T_MAX = WT'(TIMEOUT);
  localparam logic signed [AT:0] HIST = AT1'(HISTERESIS);

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    FRIO     = 2'b01,
    CALIENTE = 2'b10,
    FALLA    = 2'b11
  } estado_t;

  logic err_q;
  logic signed [AT:0] umbral_frio;
  logic signed [AT:0] umbral_calor;

  // one extra bit so limit +/- margin never wraps
  assign umbral_frio  = {bus.lim_bajo[AT-1], bus.lim_bajo} + HIST;
  assign umbral_calor = {bus.lim_alto[AT-1], bus.lim_alto} - HIST;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (bus.lim_bajo >= bus.lim_alto);
    end
  end

  assign bus.error_config = err_q;
  assign bus.alerta = (|bus.alerta_canal) | err_q;

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    logic signed [AT-1:0] s;
    logic signed [AT:0]   s_x;
    logic                 v;
    logic                 es_frio;
    logic                 es_calor;
    logic                 falla_hit;
    logic                 limpiar;
    estado_t              st_q;
    estado_t              st_d;
    logic [WP-1:0]        cf_q, cf_d, cf_base;
    logic [WP-1:0]        cc_q, cc_d, cc_base;
    logic [WT-1:0]        ct_q, ct_d;

    assign s        = bus.temp_entrada[i*AT +: AT];
    assign s_x      = {s[AT-1], s};
    assign v        = bus.temp_valida[i];
    assign es_frio  = v && (s < bus.lim_bajo);
    assign es_calor = v && (s > bus.lim_alto);

    assign ct_d = v ? '0
                : (ct_q == T_MAX) ? T_MAX
                : ct_q + 1'b1;
    assign falla_hit = !v && (ct_d == T_MAX);

    // leaving FALLA restarts persistence from this sample
    assign cf_base = (st_q == FALLA) ? '0 : cf_q;
    assign cc_base = (st_q == FALLA) ? '0 : cc_q;

    assign cf_d = !v ? cf_q
                : !es_frio ? '0
                : (cf_base == P_MAX) ? P_MAX
                : cf_base + 1'b1;
    assign cc_d = !v ? cc_q
                : !es_calor ? '0
                : (cc_base == P_MAX) ? P_MAX
                : cc_base + 1'b1;

    always_comb begin
      st_d = st_q;
      unique case (st_q)
        NORMAL: begin
          if (cf_d == P_MAX)
            st_d = FRIO;
          else if (cc_d == P_MAX)
            st_d = CALIENTE;
        end
        FRIO: begin
          if (cc_d == P_MAX)
            st_d = CALIENTE;
          else if (v && s_x >= umbral_frio)
            st_d = NORMAL;
        end
        CALIENTE: begin
          if (cf_d == P_MAX)
            st_d = FRIO;
          else if (v && s_x <= umbral_calor)
            st_d = NORMAL;
        end
        FALLA: begin
          if (v)
            st_d = NORMAL;
        end
        default: st_d = NORMAL;
      endcase
      if (falla_hit)
        st_d = FALLA;
      else if (err_q && st_d != FALLA)
        st_d = NORMAL;
    end

    assign limpiar = err_q && (st_d != FALLA);

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        st_q <= NORMAL;
        cf_q <= '0;
        cc_q <= '0;
        ct_q <= '0;
      end else begin
        st_q <= st_d;
        cf_q <= limpiar ? '0 : cf_d;
        cc_q <= limpiar ? '0 : cc_d;
        ct_q <= ct_d;
      end
    end

    assign bus.estado_actual[2*i +: 2] = st_q;
    assign bus.calefactor[i]   = (st_q == FRIO);
    assign bus.ventilador[i]   = (st_q == CALIENTE);
    assign bus.alerta_canal[i] = (st_q == FALLA);
  end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Directed and randomized bench for monitoreo_multicanal
// against an integer reference model of the channel rules.
module tb_monitoreo_multicanal;
  localparam int N  = 4;
  localparam int AT = 11;
  localparam int P  = 5;
  localparam int H  = 20;
  localparam int T  = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  monitoreo_multicanal_if #(.N_CANALES(N), .ANCHO_TEMP(AT)) bus ();

  monitoreo_multicanal #(
    .N_CANALES(N), .ANCHO_TEMP(AT), .PERSISTENCIA(P),
    .HISTERESIS(H), .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus)
  );

  int t_in [N];
  bit val  [N];
  int lb, la;
  int st_m [N];
  int cf_m [N];
  int cc_m [N];
  int ct_m [N];
  bit err_m;
  int passed = 0;
  int total = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.temp_entrada[i*AT +: AT] = AT'(t_in[i]);
      bus.temp_valida[i] = val[i];
    end
    bus.lim_bajo = AT'(lb);
    bus.lim_alto = AT'(la);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      st_m[i] = 0; cf_m[i] = 0; cc_m[i] = 0; ct_m[i] = 0;
    end
    err_m = 0;
  endtask

  // states: 0 normal, 1 cold, 2 hot, 3 fault
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int s, ns;
      bit v, fr, ca;
      s = t_in[i];
      v = val[i];
      fr = v && (s < lb);
      ca = v && (s > la);
      if (v) ct_m[i] = 0;
      else if (ct_m[i] < T) ct_m[i]++;
      if (v) begin
        if (st_m[i] == 3) begin cf_m[i] = 0; cc_m[i] = 0; end
        cf_m[i] = fr ? ((cf_m[i] < P) ? cf_m[i] + 1 : P) : 0;
        cc_m[i] = ca ? ((cc_m[i] < P) ? cc_m[i] + 1 : P) : 0;
      end
      ns = st_m[i];
      case (st_m[i])
        0: if (cf_m[i] == P) ns = 1; else if (cc_m[i] == P) ns = 2;
        1: if (cc_m[i] == P) ns = 2; else if (v && s >= lb + H) ns = 0;
        2: if (cf_m[i] == P) ns = 1; else if (v && s <= la - H) ns = 0;
        default: if (v) ns = 0;
      endcase
      if (!v && ct_m[i] >= T) ns = 3;
      else if (err_m && ns != 3) begin
        ns = 0; cf_m[i] = 0; cc_m[i] = 0;
      end
      st_m[i] = ns;
    end
    err_m = (lb >= la);
  endtask

  task automatic check_all();
    logic [2*N-1:0] e_est;
    logic [N-1:0] e_cal, e_ven, e_al;
    for (int i = 0; i < N; i++) begin
      e_est[2*i +: 2] = 2'(st_m[i]);
      e_cal[i] = (st_m[i] == 1);
      e_ven[i] = (st_m[i] == 2);
      e_al[i]  = (st_m[i] == 3);
    end
    chk("estado", 32'(bus.estado_actual), 32'(e_est));
    chk("calefactor", 32'(bus.calefactor), 32'(e_cal));
    chk("ventilador", 32'(bus.ventilador), 32'(e_ven));
    chk("alerta_canal", 32'(bus.alerta_canal), 32'(e_al));
    chk("error_config", 32'(bus.error_config), 32'(err_m));
    chk("alerta", 32'(bus.alerta), 32'((|e_al) | err_m));
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic feed(int ch, int temp, bit v, int n);
    t_in[ch] = temp;
    val[ch] = v;
    for (int k = 0; k < n; k++) step();
  endtask

  int center [N];
  int dead [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      t_in[i] = 250; val[i] = 1'b1; center[i] = 250; dead[i] = 0;
    end
    lb = 180; la = 300;
    drive();
    model_reset();
    #12;
    chk("rst_estado", 32'(bus.estado_actual), 32'h0);
    chk("rst_error_config", 32'(bus.error_config), 32'h0);
    chk("rst_alerta", 32'(bus.alerta), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;

    // async reset while ch0 is hot
    feed(0, 350, 1, 5);
    chk("ch0_caliente", 32'(bus.ventilador[0]), 32'h1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_estado", 32'(bus.estado_actual), 32'h0);
    chk("arst_ventilador", 32'(bus.ventilador), 32'h0);
    chk("arst_alerta", 32'(bus.alerta), 32'h0);
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    t_in[0] = 250;
    step();
    chk("post_rst_estado", 32'(bus.estado_actual), 32'h0);

    // persistence on ch0
    feed(0, 150, 1, 4);
    chk("cal0_4th", 32'(bus.calefactor[0]), 32'h0);
    feed(0, 150, 1, 1);
    chk("cal0_5th", 32'(bus.calefactor[0]), 32'h1);
    feed(0, 250, 1, 1);
    chk("ch0_exit_frio", 32'(bus.estado_actual[1:0]), 32'h0);
    feed(0, 150, 1, 4);
    feed(0, 200, 1, 1);
    chk("ch0_broken_persist", 32'(bus.estado_actual[1:0]), 32'h0);
    feed(0, 250, 1, 1);

    // hysteresis on ch1
    feed(1, 350, 1, 5);
    chk("ven1_on", 32'(bus.ventilador[1]), 32'h1);
    feed(1, 290, 1, 1);
    chk("ven1_in_band", 32'(bus.ventilador[1]), 32'h1);
    feed(1, 280, 1, 1);
    chk("ven1_exit", 32'(bus.ventilador[1]), 32'h0);

    // gaps keep persistence on ch2
    feed(2, 150, 1, 3);
    feed(2, 150, 0, 4);
    feed(2, 150, 1, 1);
    chk("cal2_4th_valid", 32'(bus.calefactor[2]), 32'h0);
    feed(2, 150, 1, 1);
    chk("cal2_5th_valid", 32'(bus.calefactor[2]), 32'h1);
    feed(2, 250, 1, 1);

    // timeout on ch3
    feed(3, 250, 0, 15);
    chk("al3_15", 32'(bus.alerta_canal[3]), 32'h0);
    feed(3, 250, 0, 1);
    chk("al3_16", 32'(bus.alerta_canal[3]), 32'h1);
    chk("est3_falla", 32'(bus.estado_actual[7:6]), 32'h3);
    chk("alerta_falla", 32'(bus.alerta), 32'h1);
    feed(3, 250, 1, 1);
    chk("est3_recover", 32'(bus.estado_actual[7:6]), 32'h0);
    chk("alerta_clear", 32'(bus.alerta), 32'h0);

    // inconsistent limits force NORMAL
    feed(0, 150, 1, 5);
    chk("cal0_before_cfg", 32'(bus.calefactor[0]), 32'h1);
    lb = 300;
    feed(0, 150, 1, 1);
    chk("cfg_err_on", 32'(bus.error_config), 32'h1);
    chk("cfg_alerta", 32'(bus.alerta), 32'h1);
    feed(0, 150, 1, 1);
    chk("cfg_forced_normal", 32'(bus.estado_actual[1:0]), 32'h0);
    lb = 180;
    feed(0, 250, 1, 1);
    chk("cfg_err_off", 32'(bus.error_config), 32'h0);

    // randomized phase
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        case ($urandom_range(0, 5))
          0: begin lb = -1024; la = 1023; end
          1: begin lb = 250; la = 250; end
          default: begin
            lb = $urandom_range(120, 220);
            la = $urandom_range(260, 360);
          end
        endcase
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 29) == 0)
          center[i] = 100 + 150 * $urandom_range(0, 2);
        if (dead[i] > 0) dead[i]--;
        else if ($urandom_range(0, 59) == 0)
          dead[i] = $urandom_range(10, 25);
        val[i] = (dead[i] == 0) && ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 31) == 0)
          t_in[i] = $urandom_range(0, 1) ? 1023 : -1024;
        else
          t_in[i] = center[i] + $urandom_range(0, 80) - 40;
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
